// File: rtl/rv_run_ctrl_if.sv
// Run-control bus between the debug host and rv_run_ctrl: requests, step/breakpoint setup,
// the writeback commit stream, and the stall/status/snapshot outputs.
interface rv_run_ctrl_if #(
  parameter int unsigned STEP_W = 16,
  parameter int unsigned CNT_W  = 32
);
  logic              halt_req;
  logic              resume_req;
  logic              step_req;
  logic [STEP_W-1:0] step_count;
  logic              bp_en;
  logic [31:0]       bp_pc;
  logic              fetch_fire;
  logic              commit_valid;
  logic [31:0]       commit_pc;
  logic [4:0]        commit_rd;
  logic [31:0]       commit_data;
  logic              cnt_clear;

  logic              core_stall;
  logic              halted;
  logic [1:0]        run_state;
  logic [1:0]        halt_cause;
  logic [CNT_W-1:0]  commit_cnt;
  logic [31:0]       last_pc;
  logic [4:0]        last_rd;
  logic [31:0]       last_data;

  modport master (
    output halt_req, resume_req, step_req, step_count, bp_en, bp_pc, fetch_fire,
           commit_valid, commit_pc, commit_rd, commit_data, cnt_clear,
    input  core_stall, halted, run_state, halt_cause, commit_cnt, last_pc, last_rd, last_data
  );

  modport slave (
    input  halt_req, resume_req, step_req, step_count, bp_en, bp_pc, fetch_fire,
           commit_valid, commit_pc, commit_rd, commit_data, cnt_clear,
    output core_stall, halted, run_state, halt_cause, commit_cnt, last_pc, last_rd, last_data
  );
endinterface

// File: rtl/rv_run_ctrl.sv
// Debug run-control for the pipelined RV32 core: run/halt/step/breakpoint sequencing via a
// registered fetch stall, plus a commit counter and last-commit snapshot.
module rv_run_ctrl #(
  parameter int unsigned DRAIN_CYCLES  = 4,
  parameter int unsigned STEP_W        = 16,
  parameter int unsigned CNT_W         = 32,
  parameter bit          HALT_ON_RESET = 1'b0
) (
  input logic          clk,
  input logic          reset_n,
  rv_run_ctrl_if.slave ctrl
);

  localparam int unsigned DrainW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  localparam logic [1:0] CauseNone = 2'd0;
  localparam logic [1:0] CauseHalt = 2'd1;
  localparam logic [1:0] CauseBp   = 2'd2;
  localparam logic [1:0] CauseStep = 2'd3;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StHalting = 2'd1,
    StHalted  = 2'd2,
    StStep    = 2'd3
  } state_e;

  state_e            r_state;
  logic              r_stall;
  logic              r_halted;
  logic [1:0]        r_cause;
  logic [DrainW-1:0] r_drain;
  logic [STEP_W-1:0] r_budget;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_last_pc;
  logic [4:0]        r_last_rd;
  logic [31:0]       r_last_data;

  logic              w_bp_hit;
  logic [STEP_W-1:0] w_step_load;

  assign w_bp_hit    = ctrl.commit_valid & ctrl.bp_en & (ctrl.commit_pc == ctrl.bp_pc);
  assign w_step_load = (ctrl.step_count == '0) ? STEP_W'(1) : ctrl.step_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= HALT_ON_RESET ? StHalted : StRun;
      r_stall  <= HALT_ON_RESET;
      r_halted <= HALT_ON_RESET;
      r_cause  <= CauseNone;
      r_drain  <= '0;
      r_budget <= '0;
    end else begin
      case (r_state)
        StRun: begin
          if (w_bp_hit || ctrl.halt_req) begin
            r_state <= StHalting;
            r_stall <= 1'b1;
            r_drain <= DrainW'(DRAIN_CYCLES);
            r_cause <= w_bp_hit ? CauseBp : CauseHalt;
          end
        end
        StHalting: begin
          // Any commit restarts the drain window so HALTED guarantees a quiet pipeline.
          if (ctrl.commit_valid) begin
            r_drain <= DrainW'(DRAIN_CYCLES);
          end else if (r_drain <= DrainW'(1)) begin
            r_drain  <= '0;
            r_state  <= StHalted;
            r_halted <= 1'b1;
          end else begin
            r_drain <= r_drain - DrainW'(1);
          end
        end
        StHalted: begin
          if (ctrl.step_req) begin
            r_state  <= StStep;
            r_stall  <= 1'b0;
            r_halted <= 1'b0;
            r_cause  <= CauseNone;
            r_budget <= w_step_load;
          end else if (ctrl.resume_req) begin
            r_state  <= StRun;
            r_stall  <= 1'b0;
            r_halted <= 1'b0;
            r_cause  <= CauseNone;
          end
        end
        StStep: begin
          if (w_bp_hit || ctrl.halt_req) begin
            r_state <= StHalting;
            r_stall <= 1'b1;
            r_drain <= DrainW'(DRAIN_CYCLES);
            r_cause <= w_bp_hit ? CauseBp : CauseHalt;
          end else if (ctrl.fetch_fire && (r_budget != '0)) begin
            r_budget <= r_budget - STEP_W'(1);
            if (r_budget == STEP_W'(1)) begin
              r_state <= StHalting;
              r_stall <= 1'b1;
              r_drain <= DrainW'(DRAIN_CYCLES);
              r_cause <= CauseStep;
            end
          end
        end
        default: begin
          r_state  <= StHalted;
          r_stall  <= 1'b1;
          r_halted <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (ctrl.cnt_clear) begin
      r_cnt <= '0;
    end else if (ctrl.commit_valid) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_pc   <= '0;
      r_last_rd   <= '0;
      r_last_data <= '0;
    end else if (ctrl.commit_valid) begin
      r_last_pc   <= ctrl.commit_pc;
      r_last_rd   <= ctrl.commit_rd;
      r_last_data <= ctrl.commit_data;
    end
  end

  assign ctrl.core_stall = r_stall;
  assign ctrl.halted     = r_halted;
  assign ctrl.run_state  = r_state;
  assign ctrl.halt_cause = r_cause;
  assign ctrl.commit_cnt = r_cnt;
  assign ctrl.last_pc    = r_last_pc;
  assign ctrl.last_rd    = r_last_rd;
  assign ctrl.last_data  = r_last_data;

endmodule

// File: doc/rv_run_ctrl.md
Name: rv_run_ctrl

Overview:
- Debug run-control controller for the pipelined RV32 core.
- Sequences the core through run, halt, single/multi-step and PC-breakpoint halts by driving a fetch-stall into the hazard stage.
- Observes the writeback commit stream (valid/pc/rd/data) and keeps a commit counter plus a last-commit snapshot.
- Sits beside the core, between the debug/testbench host and the core's stall input.

Parameters:
- DRAIN_CYCLES, 4, cycles to hold stall after fetch stops before declaring halted (pipeline depth minus 1)
- STEP_W, 16, width of step_count and internal step budget
- CNT_W, 32, width of commit counter
- HALT_ON_RESET, 0, 1 = leave reset in HALTED instead of RUN

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- halt_req  in  1  one-cycle pulse: request halt
- resume_req  in  1  one-cycle pulse: resume free run (only honoured in HALTED)
- step_req  in  1  one-cycle pulse: step step_count instructions (only honoured in HALTED)
- step_count  in  STEP_W  instructions to fetch per step; 0 treated as 1
- bp_en  in  1  breakpoint enable
- bp_pc  in  32  breakpoint commit PC
- fetch_fire  in  1  IF stage accepted an instruction this cycle
- commit_valid  in  1  writeback commit strobe
- commit_pc  in  32  committed PC
- commit_rd  in  5  committed rd
- commit_data  in  32  committed write data
- cnt_clear  in  1  synchronous clear of commit_cnt
- core_stall  out  1  registered; freezes PC/IF/ID when 1
- halted  out  1  registered; 1 only in HALTED
- run_state  out  2  0 RUN, 1 HALTING, 2 HALTED, 3 STEP
- halt_cause  out  2  0 none, 1 halt_req, 2 breakpoint, 3 step done
- commit_cnt  out  CNT_W  commits observed since reset/clear
- last_pc, last_rd, last_data  out  32/5/32  snapshot of most recent commit

Behaviour:
- Reset (async, reset_n=0):
  - HALT_ON_RESET=0: run_state=RUN, core_stall=0, halted=0.
  - HALT_ON_RESET=1: run_state=HALTED, core_stall=1, halted=1.
  - halt_cause=0, commit_cnt=0, last_*=0, drain counter=0, step budget=0.
  - Reset mid-step/mid-drain abandons the operation with no residue.
- All state updates on posedge clk; outputs registered, so a decision on cycle N is visible on cycle N+1.
- RUN:
  - halt_req -> HALTING, cause=1.
  - commit_valid && bp_en && commit_pc==bp_pc -> HALTING, cause=2.
  - If both occur the same cycle, cause=2.
  - resume_req and step_req are ignored.
- HALTING:
  - core_stall=1; drain counter loads DRAIN_CYCLES on entry and decrements each cycle.
  - At 0 -> HALTED. The count restarts if commit_valid is seen, so HALTED implies DRAIN_CYCLES commit-free cycles.
  - halt_req, resume_req and step_req are ignored.
- HALTED:
  - core_stall=1, halted=1.
  - step_req -> STEP: budget = max(step_count,1), cause cleared to 0.
  - resume_req -> RUN, cause=0.
  - step_req wins over simultaneous resume_req; halt_req is ignored.
- STEP:
  - core_stall=0 while budget>0; each fetch_fire decrements the budget.
  - The fetch_fire that takes the budget to 0 sets core_stall=1 on the next cycle and moves to HALTING with cause=3.
  - halt_req in STEP aborts -> HALTING, cause=1.
  - A breakpoint hit in STEP -> HALTING, cause=2 (priority: bp > halt_req > step done).
- Commit counter:
  - commit_valid -> commit_cnt+1 in every state, wrapping modulo 2^CNT_W.
  - cnt_clear forces 0; if commit_valid arrives the same cycle, clear wins and the result is 0.
- Snapshot: on commit_valid, last_pc/last_rd/last_data capture the commit inputs in every state. Commits with rd=0 are still counted and captured.
- Breakpoint compare is full 32-bit equality on commit_pc; no match is possible while bp_en=0.
- Illegal run_state encodings are unreachable; the default branch returns to HALTED with core_stall=1.

Test Plan:
- Reset with HALT_ON_RESET=0, 10 commits with pcs 0x0..0x24 -> commit_cnt=10, last_pc=0x24, core_stall=0, run_state=0.
- halt_req pulse while commits continue for 2 cycles, DRAIN_CYCLES=4 -> core_stall=1 on the next cycle; halted=1 exactly 4 cycles after the final commit; halt_cause=1.
- bp_en=1, bp_pc=0x40, commit stream reaches 0x40 -> halt_cause=2, halted=1; last_pc=0x40 plus any drained commits; a same-cycle halt_req still gives cause=2.
- From HALTED: step_req with step_count=3 and three fetch_fire pulses -> core_stall low for exactly those 3 fetches, then HALTED with cause=3. step_count=0 allows exactly 1 fetch.
- HALTED, step_req and resume_req in the same cycle -> STEP taken (run_state=3). Later resume_req -> RUN, cause=0, core_stall=0.
- commit_cnt preset to 0xFFFFFFFF via commits, one more commit -> 0. cnt_clear coincident with commit_valid -> 0. reset_n dropped mid-STEP -> immediate RUN, all outputs at reset values with no clock edge.
